// File: rtl/signed_sum_accumulator_pkg.sv
// Shared types and constants for the signed sum accumulator: FSM state,
// default widths/frame length and the accumulator rail values.
package signed_sum_pkg;

  localparam int DEF_IN_W  = 5;
  localparam int DEF_ACC_W = 8;
  localparam int DEF_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic int acc_max(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_min(input int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/signed_sum_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle for signed_sum_accumulator.
interface signed_sum_accumulator_if #(
  parameter int IN_W  = signed_sum_pkg::DEF_IN_W,
  parameter int ACC_W = signed_sum_pkg::DEF_ACC_W
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;
  logic             out_ovf_seen;
  logic             busy;

  modport master (
    output in_valid, in_sum, in_ovf, out_ready,
    input  in_ready, out_valid, out_acc, out_sat, out_ovf_seen, busy
  );

  modport slave (
    input  in_valid, in_sum, in_ovf, out_ready,
    output in_ready, out_valid, out_acc, out_sat, out_ovf_seen, busy
  );

endinterface

// File: rtl/signed_sum_accumulator_sat_adder.sv
// ACC_W-wide signed add of a sign-extended IN_W operand. With
// SIGNED_SUM_ACC_SAT_EN defined the result clamps to the rails and flags sat.
module sat_adder
  import signed_sum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat
);

`ifdef SIGNED_SUM_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

  logic signed [ACC_W:0] wide;

  always_comb begin
    wide = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
    sum  = wide[ACC_W-1:0];
    sat  = 1'b0;
    // Top two bits disagree only when the true sum left the ACC_W range.
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat = 1'b1;
      sum = wide[ACC_W] ? MIN_V : MAX_V;
    end
  end
`else
  always_comb begin
    sum = a + {{(ACC_W - IN_W){b[IN_W-1]}}, b};
    sat = 1'b0;
  end
`endif

endmodule

// File: rtl/signed_sum_accumulator.sv
// Accumulates COUNT signed samples per frame and presents the frame result
// on an output handshake; saturation depends on SIGNED_SUM_ACC_SAT_EN.
module signed_sum_accumulator
  import signed_sum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = DEF_COUNT
) (
  input logic                      clk,
  input logic                      rst,
  signed_sum_accumulator_if.slave  bus
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;

  logic                    in_ready;
  logic                    out_valid;
  logic                    accept;
  logic signed [ACC_W-1:0] add_a;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_sat;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = bus.in_valid && in_ready;

  // The first sample of a frame is added to zero, so it never saturates.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  sat_adder #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_sat_adder (
    .a  (add_a),
    .b  (bus.in_sum),
    .sum(add_sum),
    .sat(add_sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = add_sum;
          cnt_d   = 8'd1;
          ovf_d   = bus.in_ovf;
          sat_d   = 1'b0;
          state_d = (COUNT == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | bus.in_ovf;
          sat_d = sat_q | add_sat;
          if (cnt_q == 8'(COUNT - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_acc      = out_valid ? acc_q : '0;
  assign bus.out_sat      = out_valid & sat_q;
  assign bus.out_ovf_seen = out_valid & ovf_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Scoreboard bench for signed_sum_accumulator: defaults, a 6-bit accumulator
// and a single-sample frame variant run side by side on one clock.
module tb_signed_sum_accumulator;
  import signed_sum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signed_sum_accumulator_if #(.IN_W(5), .ACC_W(8)) ia ();
  signed_sum_accumulator_if #(.IN_W(5), .ACC_W(6)) ib ();
  signed_sum_accumulator_if #(.IN_W(5), .ACC_W(8)) ic ();

  signed_sum_accumulator #(.IN_W(5), .ACC_W(8), .COUNT(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  signed_sum_accumulator #(.IN_W(5), .ACC_W(6), .COUNT(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  signed_sum_accumulator #(.IN_W(5), .ACC_W(8), .COUNT(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

`ifdef SIGNED_SUM_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    int acc;
    bit sat;
    bit ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: one accumulation step at width w.
  function automatic exp_t step(input exp_t e, input int s, input bit o, input int w);
    int hi, lo, m, sum;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    m   = 1 << w;
    sum = e.acc + s;
    if (SAT_EN) begin
      if (sum > hi) begin sum = hi; e.sat = 1'b1; end
      else if (sum < lo) begin sum = lo; e.sat = 1'b1; end
    end else begin
      sum = ((sum - lo) % m + m) % m + lo;
    end
    e.acc = sum;
    e.ovf = e.ovf | o;
    return e;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.acc = 0; e.sat = 1'b0; e.ovf = 1'b0;
    return e;
  endfunction

  task automatic put_a(input int s, input bit o);
    int n;
    n = 0;
    ia.in_valid = 1'b1; ia.in_sum = 5'(s); ia.in_ovf = o;
    while (!ia.in_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 20) begin
      n_err++;
      $display("FAIL put_a_timeout: in_ready=%b required 1", ia.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 1'b0;
  endtask

  task automatic frame_a(input int s[4], input bit o[4]);
    exp_t e;
    e = blank();
    for (int i = 0; i < 4; i++) e = step(e, s[i], o[i], 8);
    q_a.push_back(e);
    for (int i = 0; i < 4; i++) put_a(s[i], o[i]);
  endtask

  task automatic test_reset();
    ia.in_valid = 0; ia.in_sum = '0; ia.in_ovf = 0; ia.out_ready = 0;
    ib.in_valid = 0; ib.in_sum = '0; ib.in_ovf = 0; ib.out_ready = 0;
    ic.in_valid = 0; ic.in_sum = '0; ic.in_ovf = 0; ic.out_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({ia.in_ready, ia.out_valid, ia.busy, ia.out_acc, ia.out_sat, ia.out_ovf_seen} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_a: rdy=%b vld=%b busy=%b acc=%0d sat=%b ovf=%b required 1 0 0 0 0 0",
               ia.in_ready, ia.out_valid, ia.busy, ia.out_acc, ia.out_sat, ia.out_ovf_seen);
    end
    n_cmp++;
    if ({ib.in_ready, ib.out_valid, ib.busy, ic.in_ready, ic.out_valid, ic.busy} !== 6'b100100) begin
      n_err++;
      $display("FAIL reset_bc: b rdy/vld/busy=%b%b%b c=%b%b%b required 100 100",
               ib.in_ready, ib.out_valid, ib.busy, ic.in_ready, ic.out_valid, ic.busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    ia.out_ready = 1'b1;
    frame_a('{8, 8, 8, 8}, '{0, 0, 0, 0});
    e = q_a.pop_front();
    n_cmp++;
    if (ia.out_valid !== 1'b1 || int'($signed(ia.out_acc)) !== e.acc || ia.out_sat !== e.sat || ia.out_ovf_seen !== e.ovf) begin
      n_err++;
      $display("FAIL b2b_result: vld=%b acc=%0d sat=%b ovf=%b required 1 %0d %b %b",
               ia.out_valid, $signed(ia.out_acc), ia.out_sat, ia.out_ovf_seen, e.acc, e.sat, e.ovf);
    end
    @(negedge clk);
    n_cmp++;
    if ({ia.out_valid, ia.in_ready, ia.busy, ia.out_acc} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL b2b_idle: vld=%b rdy=%b busy=%b acc=%0d required 0 1 0 0",
               ia.out_valid, ia.in_ready, ia.busy, ia.out_acc);
    end
  endtask

  task automatic test_ovf_record();
    exp_t e;
    frame_a('{13, -10, -6, 0}, '{1, 1, 0, 0});
    e = q_a.pop_front();
    n_cmp++;
    if (ia.out_valid !== 1'b1 || int'($signed(ia.out_acc)) !== e.acc || ia.out_sat !== e.sat || ia.out_ovf_seen !== e.ovf) begin
      n_err++;
      $display("FAIL ovf_result: vld=%b acc=%0d sat=%b ovf=%b required 1 %0d %b %b",
               ia.out_valid, $signed(ia.out_acc), ia.out_sat, ia.out_ovf_seen, e.acc, e.sat, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_width6();
    exp_t e;
    e = blank();
    for (int i = 0; i < 4; i++) e = step(e, 15, 1'b0, 6);
    q_b.push_back(e);
    ib.out_ready = 1'b1;
    ib.in_valid  = 1'b1;
    ib.in_sum    = 5'd15;
    for (int i = 0; i < 4; i++) begin @(posedge clk); @(negedge clk); end
    ib.in_valid = 1'b0;
    e = q_b.pop_front();
    n_cmp++;
    if (ib.out_valid !== 1'b1 || int'($signed(ib.out_acc)) !== e.acc || ib.out_sat !== e.sat) begin
      n_err++;
      $display("FAIL w6_result: vld=%b acc=%0d sat=%b required 1 %0d %b",
               ib.out_valid, $signed(ib.out_acc), ib.out_sat, e.acc, e.sat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    ia.out_ready = 1'b0;
    frame_a('{1, 2, 3, 4}, '{0, 0, 0, 0});
    e = q_a.pop_front();
    ia.in_valid = 1'b1; ia.in_sum = 5'd7; ia.in_ovf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || int'($signed(ia.out_acc)) !== e.acc) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b acc=%0d required 0 1 %0d",
                 k, ia.in_ready, ia.out_valid, $signed(ia.out_acc), e.acc);
      end
    end
    ia.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: vld=%b required 0", ia.out_valid);
    end
    frame_a('{7, -2, -2, -2}, '{0, 0, 0, 0});
    e = q_a.pop_front();
    n_cmp++;
    if (ia.out_valid !== 1'b1 || int'($signed(ia.out_acc)) !== e.acc || ia.out_sat !== e.sat) begin
      n_err++;
      $display("FAIL bp_next_frame: vld=%b acc=%0d sat=%b required 1 %0d %b",
               ia.out_valid, $signed(ia.out_acc), ia.out_sat, e.acc, e.sat);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_reset();
    exp_t e;
    ia.out_ready = 1'b1;
    put_a(5, 1'b1);
    put_a(5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({ia.busy, ia.out_valid, ia.in_ready} !== 3'b101) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: busy=%b vld=%b rdy=%b required 1 0 1",
                 k, ia.busy, ia.out_valid, ia.in_ready);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ia.in_ready, ia.out_valid, ia.busy, ia.out_acc, ia.out_sat, ia.out_ovf_seen} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: rdy=%b vld=%b busy=%b acc=%0d sat=%b ovf=%b required 1 0 0 0 0 0",
               ia.in_ready, ia.out_valid, ia.busy, ia.out_acc, ia.out_sat, ia.out_ovf_seen);
    end
    @(negedge clk);
    rst = 1'b0;
    frame_a('{1, 1, 1, 1}, '{0, 0, 0, 0});
    e = q_a.pop_front();
    n_cmp++;
    if (ia.out_valid !== 1'b1 || int'($signed(ia.out_acc)) !== e.acc || ia.out_ovf_seen !== e.ovf) begin
      n_err++;
      $display("FAIL post_reset_frame: vld=%b acc=%0d ovf=%b required 1 %0d %b",
               ia.out_valid, $signed(ia.out_acc), ia.out_ovf_seen, e.acc, e.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_count1();
    exp_t e;
    int   s;
    logic exp_v;
    ic.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_v = ((i % 2) == 1);
      n_cmp++;
      if (ic.out_valid !== exp_v) begin
        n_err++;
        $display("FAIL c1_cadence[%0d]: vld=%b required %b", i, ic.out_valid, exp_v);
      end
      if (ic.out_valid === 1'b1 && q_c.size() > 0) begin
        e = q_c.pop_front();
        n_cmp++;
        if (int'($signed(ic.out_acc)) !== e.acc || ic.out_sat !== e.sat) begin
          n_err++;
          $display("FAIL c1_result[%0d]: acc=%0d sat=%b required %0d %b",
                   i, $signed(ic.out_acc), ic.out_sat, e.acc, e.sat);
        end
      end
      s = (i == 0) ? -16 : i - 8;
      ic.in_valid = 1'b1; ic.in_sum = 5'(s); ic.in_ovf = 1'b0;
      if (ic.in_ready === 1'b1) q_c.push_back(step(blank(), s, 1'b0, 8));
      @(negedge clk);
    end
    ic.in_valid = 1'b0;
    n_cmp++;
    if (q_c.size() != 0) begin
      n_err++;
      $display("FAIL c1_scoreboard: pending=%0d required 0", q_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ovf_record();
    test_width6();
    test_backpressure();
    test_stall_reset();
    test_count1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signed_sum_accumulator.md
Name: signed_sum_accumulator

Overview:
- Downstream consumer of the 4-bit signed adder stage. Takes its 5-bit signed sum and overflow flag, one sample per valid/ready handshake.
- Accumulates COUNT samples into a wider signed accumulator, saturating at the accumulator limits, then presents the frame result on an output handshake.
- Sits between the adder datapath and any reporting or compare logic.

Parameters:
- IN_W, 5, width of the incoming signed sum (two's complement).
- ACC_W, 8, accumulator and result width (signed). Legal only when ACC_W > IN_W.
- COUNT, 4, samples per frame. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_sum and in_ovf are valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  IN_W  signed sum from the adder stage.
- in_ovf  input  1  overflow flag from the adder stage.
- out_valid  output  1  frame result is valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  signed accumulated frame result.
- out_sat  output  1  saturation occurred at any point in this frame.
- out_ovf_seen  output  1  in_ovf was high on any accepted sample of this frame.
- busy  output  1  frame in progress (state ACCUM or DONE).

Behaviour:
- Reset (async assert, released synchronously to clk): state=IDLE, acc=0, cnt=0, sat=0, ovf=0, out_valid=0, in_ready=1, busy=0, out_acc=0, out_sat=0, out_ovf_seen=0.
- A sample is accepted on any edge where in_valid && in_ready.
- in_ready = (state != DONE). No input is accepted while a result is pending.
- FSM states:
  - IDLE: on accept, acc = sext(in_sum); cnt = 1; ovf = in_ovf; sat = 0. Go to DONE if COUNT==1, else ACCUM.
  - ACCUM: on accept, acc = sat_add(acc, sext(in_sum)); cnt++; ovf |= in_ovf; sat |= sat_event. Go to DONE when the accepted sample is sample number COUNT. With no accept, hold all state.
  - DONE: out_valid=1, out_acc=acc, out_sat=sat, out_ovf_seen=ovf. On out_valid && out_ready, go to IDLE and clear acc, cnt, sat and ovf in that same edge.
- Latency: out_valid rises on the cycle after the edge that accepted the COUNT-th sample. Result stays stable until accepted.
- Arithmetic:
  - Sum computed at ACC_W+1 bits.
  - Result > 2^(ACC_W-1)-1: clamp to that maximum and set sat_event.
  - Result < -2^(ACC_W-1): clamp to that minimum and set sat_event.
  - Clamping is applied per sample; later samples may move acc off the rail.
- in_ovf is recorded only. in_sum is already the 5-bit correct sum, so no correction is applied.
- out_acc, out_sat and out_ovf_seen read 0 whenever out_valid=0.
- Gaps in in_valid at any point are legal; the frame simply stalls.
- Reset mid-frame or mid-DONE discards the partial frame or pending result immediately; no output is produced for it.

Optional Feature:
- Macro: SIGNED_SUM_ACC_SAT_EN.
- Defined: saturating behaviour exactly as above.
- Not defined: acc wraps modulo 2^ACC_W; sat_event never asserts and out_sat is tied 0. Handshake, FSM and latency are unchanged.

Decomposition:
- Shared package signed_sum_pkg:
  - state enum (IDLE, ACCUM, DONE)
  - ACC_MAX/ACC_MIN constant functions of ACC_W
  - default IN_W/ACC_W/COUNT constants
- One natural sub-module: sat_adder (ACC_W-wide signed add, sign extension of the IN_W operand, clamp, sat flag). With the macro off it reduces to a plain wrap add.
- FSM, counter and handshake stay in the top.

Test Plan:
- Defaults. Four samples of +8 with back-to-back in_valid and out_ready=1 → one cycle after the 4th accept, out_valid=1, out_acc=32, out_sat=0, out_ovf_seen=0; next cycle IDLE with in_ready=1.
- Samples 13, -10, -6, 0, with in_ovf=1 on the first two → out_acc=-3, out_ovf_seen=1, out_sat=0.
- ACC_W=6, macro on. Four samples of +15 → out_acc=31, out_sat=1. Repeat with macro off → out_acc=-4 (60 wraps to -4), out_sat=0.
- Backpressure. Hold out_ready=0 for 5 cycles in DONE with in_valid=1 → in_ready=0, out_acc stable, no sample consumed; after release, the next frame starts from 0.
- Stall and reset. Accept 2 samples, deassert in_valid for 3 cycles (state held), then pulse rst asynchronously mid-cycle → all outputs are at reset values immediately; the next full frame of four +1 samples gives out_acc=4.
- COUNT=1. A single sample of -16 → out_valid on the next cycle with out_acc=-16; repeated frames with out_ready held high produce one result every 2 cycles.
